gpio_bus_arbiter: RTL and testbench
===================================

Name: gpio_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the GPIO register port (addr / wrEnable / wrData / rdData).
- Lets the CPU data-bus bridge (master 0) and the debug/test port (master 1) share one GPIO instance.
- Provides a valid/ready handshake per master, round-robin fairness, and a lock for atomic read-modify-write.
- Sits between the bus bridges and the GPIO slave; one access per 3 cycles.

Parameters:
ADDR_WIDTH, 4, GPIO register address width
DATA_WIDTH, 8, GPIO data width
LOCK_TIMEOUT, 15, max idle cycles a lock may hold the bus; 0 = no timeout

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_m0_valid  in  1  master 0 request
i_m0_addr  in  ADDR_WIDTH  master 0 address
i_m0_wrEnable  in  1  master 0: 1 = write, 0 = read
i_m0_wrData  in  DATA_WIDTH  master 0 write data
i_m0_lock  in  1  master 0 requests bus hold after this transfer
o_m0_ready  out  1  master 0 transfer complete (1-cycle pulse)
o_m0_rdData  out  DATA_WIDTH  read data, valid with o_m0_ready
i_m1_valid, i_m1_addr, i_m1_wrEnable, i_m1_wrData, i_m1_lock, o_m1_ready, o_m1_rdData  same as master 0
o_s_addr  out  ADDR_WIDTH  to GPIO i_addr
o_s_wrEnable  out  1  to GPIO i_wrEnable
o_s_wrData  out  DATA_WIDTH  to GPIO i_wrData
i_s_rdData  in  DATA_WIDTH  from GPIO o_rdData (combinational read)
o_lockTimeout  out  1  1-cycle pulse when a lock is revoked by timeout

Behaviour:
- Reset (i_reset low, async):
  - State IDLE; last-grant pointer = 1, so master 0 wins the first tie.
  - grant = 0; o_s_addr / o_s_wrData / rdData register = 0.
  - o_s_wrEnable, o_mX_ready and o_lockTimeout = 0; timeout counter = 0.
  - Reset mid-transfer abandons the transfer and drops o_s_wrEnable immediately. No ready is issued; masters reissue.
- Handshake:
  - A master holds valid and payload stable until its ready pulse.
  - Transfer completes on valid && ready.
  - If valid drops early, the latched payload still executes and ready still pulses; the master ignores it.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: grant that master.
  - Both valid: grant the master != last grant.
  - On grant: latch addr / wrEnable / wrData into o_s_*; update last grant; go to ACCESS.
- ACCESS (1 cycle):
  - o_s_wrEnable = latched wrEnable (only state where it can be 1).
  - Capture i_s_rdData into the rdData register. A write returns the pre-write value.
  - Go to RESP.
- RESP (1 cycle):
  - o_m<grant>_ready = 1; the other master's ready = 0.
  - Both o_mX_rdData are driven from the rdData register.
  - If i_m<grant>_lock = 1: go to HELD and clear the counter. Otherwise go to IDLE.
- HELD:
  - Other master is not served.
  - i_m<grant>_valid: latch payload, go to ACCESS (no arbitration).
  - Else if !i_m<grant>_lock: go to IDLE.
  - Else increment the counter. When LOCK_TIMEOUT != 0 and counter reaches LOCK_TIMEOUT: pulse o_lockTimeout, go to IDLE.
  - A valid takes priority over timeout in the same cycle.
- Latency: valid sampled in IDLE at cycle N -> slave access at N+1 -> ready at N+2.
- Counter width: $clog2(LOCK_TIMEOUT+1); saturates, never wraps.
- o_s_addr and o_s_wrData hold their last value outside ACCESS.

Decomposition:
- Package gpio_bus_pkg holds:
  - state enum gpio_arb_state_t {IDLE, ACCESS, RESP, HELD}
  - GPIO_ADDR_WIDTH = 4, GPIO_DATA_WIDTH = 8
- Sub-module gpio_rr_arb2: combinational 2-way round-robin pick from (valid0, valid1, last) -> (grant, any).

Test Plan:
- Write: m0 valid, addr 0, wrEnable 1, data 0xA5 at cycle 0 -> o_s_wrEnable=1 with o_s_wrData=0xA5 at cycle 1 -> o_m0_ready at cycle 2; GPIO pins read back 0xA5.
- Read: after the write above, m1 reads addr 0 -> o_m1_ready with o_m1_rdData=0xA5; o_m0_ready stays 0.
- Contention: m0 and m1 both valid continuously from reset -> grant order m0, m1, m0, m1; ready pulses 3 cycles apart.
- Locked read-modify-write: m0 reads with lock=1 while m1 valid -> m0 writes 0x0F with lock=0 -> m1 is not served until m0's write completes, then gets the next grant.
- Lock timeout: LOCK_TIMEOUT=4; m0 holds lock, no valid -> o_lockTimeout pulses 4 cycles after entering HELD; pending m1 granted next.
- Reset mid-ACCESS: assert i_reset low during a write's ACCESS cycle -> o_s_wrEnable drops the same cycle, no ready, state IDLE; m0 wins the first request after release.

Source files
------------

// File: rtl/gpio_bus_pkg.sv
// Shared types and widths for the GPIO register-port arbiter.
// Holds the sequencer state encoding and the default GPIO bus widths.
// Imported by the arbiter top.
package gpio_bus_pkg;

  localparam int GPIO_ADDR_WIDTH = 4;
  localparam int GPIO_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    HELD
  } gpio_arb_state_t;

endpackage

// File: rtl/gpio_rr_arb2.sv
// Purpose: 2-way round-robin pick between two requesters.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module gpio_rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic grant_o,
  output logic any_o
);

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    any_o   = valid0_i | valid1_i;
    grant_o = (valid0_i && valid1_i) ? ~last_i : valid1_i;
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Purpose: two-master arbiter/sequencer in front of one GPIO register port, with RMW lock.
// Latency: valid seen in IDLE at N -> slave access at N+1 -> ready pulse at N+2; 3 cycles per access.
// Backpressure: masters hold valid until their ready pulse; a lock blocks the other master until released or timed out.
module gpio_bus_arbiter
  import gpio_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = GPIO_ADDR_WIDTH,
  parameter int DATA_WIDTH   = GPIO_DATA_WIDTH,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_m0_valid,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic                  i_m0_wrEnable,
  input  logic [DATA_WIDTH-1:0] i_m0_wrData,
  input  logic                  i_m0_lock,
  output logic                  o_m0_ready,
  output logic [DATA_WIDTH-1:0] o_m0_rdData,
  input  logic                  i_m1_valid,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic                  i_m1_wrEnable,
  input  logic [DATA_WIDTH-1:0] i_m1_wrData,
  input  logic                  i_m1_lock,
  output logic                  o_m1_ready,
  output logic [DATA_WIDTH-1:0] o_m1_rdData,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic                  o_s_wrEnable,
  output logic [DATA_WIDTH-1:0] o_s_wrData,
  input  logic [DATA_WIDTH-1:0] i_s_rdData,
  output logic                  o_lockTimeout
);

  // A zero timeout still needs a legal 1-bit counter; it simply never fires.
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_TIMEOUT);

  gpio_arb_state_t       state_q;
  logic                  last_q;
  logic                  grant_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  logic                  arb_grant;
  logic                  arb_any;
  logic                  sel;
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  own_lock;

  gpio_rr_arb2 u_rr (
    .valid0_i (i_m0_valid),
    .valid1_i (i_m1_valid),
    .last_i   (last_q),
    .grant_o  (arb_grant),
    .any_o    (arb_any)
  );

  // Payload source: the round-robin winner in IDLE, the lock owner in HELD.
  always_comb begin
    sel       = (state_q == HELD) ? grant_q : arb_grant;
    sel_valid = sel ? i_m1_valid    : i_m0_valid;
    sel_addr  = sel ? i_m1_addr     : i_m0_addr;
    sel_we    = sel ? i_m1_wrEnable : i_m0_wrEnable;
    sel_wdata = sel ? i_m1_wrData   : i_m0_wrData;
    own_lock  = grant_q ? i_m1_lock : i_m0_lock;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Sequencer: IDLE -> ACCESS -> RESP -> (HELD | IDLE), all outputs registered.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      grant_q       <= 1'b0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      o_s_addr      <= '0;
      o_s_wrData    <= '0;
      o_s_wrEnable  <= 1'b0;
      o_m0_ready    <= 1'b0;
      o_m1_ready    <= 1'b0;
      o_lockTimeout <= 1'b0;
    end else begin
      o_s_wrEnable  <= 1'b0;
      o_m0_ready    <= 1'b0;
      o_m1_ready    <= 1'b0;
      o_lockTimeout <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q      <= sel;
            last_q       <= sel;
            o_s_addr     <= sel_addr;
            o_s_wrData   <= sel_wdata;
            o_s_wrEnable <= sel_we;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          // The slave read is combinational, so a write captures the pre-write value.
          rdata_q <= i_s_rdData;
          if (grant_q) o_m1_ready <= 1'b1;
          else         o_m0_ready <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (own_lock) begin
            cnt_q   <= '0;
            state_q <= HELD;
          end else begin
            state_q <= IDLE;
          end
        end
        HELD: begin
          if (sel_valid) begin
            o_s_addr     <= sel_addr;
            o_s_wrData   <= sel_wdata;
            o_s_wrEnable <= sel_we;
            state_q      <= ACCESS;
          end else if (!own_lock) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
            if ((LOCK_TIMEOUT != 0) && (cnt_d == CNT_LIMIT)) begin
              o_lockTimeout <= 1'b1;
              state_q       <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_m0_rdData = rdata_q;
  assign o_m1_rdData = rdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: directed scenarios plus randomized two-master traffic.
// A GPIO register model serves the slave port; a reference memory predicts read data.
// Responses are scored by a monitor against per-master expectation queues.
module tb_gpio_bus_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LT = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           m_valid;
  logic [1:0][AW-1:0]   m_addr;
  logic [1:0]           m_we;
  logic [1:0][DW-1:0]   m_wdata;
  logic [1:0]           m_lock;
  logic [1:0]           m_ready;
  logic [DW-1:0]        m0_rdata;
  logic [DW-1:0]        m1_rdata;
  logic [AW-1:0]        s_addr;
  logic                 s_we;
  logic [DW-1:0]        s_wdata;
  logic [DW-1:0]        s_rdata;
  logic                 lock_to;

  logic [DW-1:0]        slv_mem [16];
  logic                 slv_clr;
  logic [DW-1:0]        ref_mem [16];
  logic [DW-1:0]        exp_q0 [$];
  logic [DW-1:0]        exp_q1 [$];
  int                   log_m [$];
  int                   log_c [$];
  int                   cyc;
  int                   errors;
  int                   checks;

  always #5 clk = ~clk;

  gpio_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_m0_valid    (m_valid[0]),
    .i_m0_addr     (m_addr[0]),
    .i_m0_wrEnable (m_we[0]),
    .i_m0_wrData   (m_wdata[0]),
    .i_m0_lock     (m_lock[0]),
    .o_m0_ready    (m_ready[0]),
    .o_m0_rdData   (m0_rdata),
    .i_m1_valid    (m_valid[1]),
    .i_m1_addr     (m_addr[1]),
    .i_m1_wrEnable (m_we[1]),
    .i_m1_wrData   (m_wdata[1]),
    .i_m1_lock     (m_lock[1]),
    .o_m1_ready    (m_ready[1]),
    .o_m1_rdData   (m1_rdata),
    .o_s_addr      (s_addr),
    .o_s_wrEnable  (s_we),
    .o_s_wrData    (s_wdata),
    .i_s_rdData    (s_rdata),
    .o_lockTimeout (lock_to)
  );

  // GPIO register file: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (slv_clr) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else if (s_we) begin
      slv_mem[s_addr] <= s_wdata;
    end
  end
  assign s_rdata = slv_mem[s_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input int m, input logic [DW-1:0] rd);
    logic [DW-1:0] e;
    log_m.push_back(m);
    log_c.push_back(cyc);
    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL spurious_ready_m%0d: ready pulsed at cycle %0d with no request pending", m, cyc);
    end else begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("rdata_m%0d", m), 32'(rd), 32'(e));
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (m_ready[0]) score(0, m0_rdata);
      if (m_ready[1]) score(1, m1_rdata);
    end
  endtask

  // Present a request and predict its response: every access returns the value held before it.
  task automatic issue(input int m, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] d, input logic lk);
    m_valid[m] = 1'b1;
    m_addr[m]  = a;
    m_we[m]    = we;
    m_wdata[m] = d;
    m_lock[m]  = lk;
    if (m == 0) exp_q0.push_back(ref_mem[a]);
    else        exp_q1.push_back(ref_mem[a]);
    if (we) ref_mem[a] = d;
  endtask

  task automatic wait_ready(input int m, output int n);
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = m_ready[m];
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout_m%0d: no ready after %0d cycles, required within 200", m, n);
    end
  endtask

  // Full transfer; returns just after the completing edge with valid still high.
  task automatic xfer(input int m, input logic [AW-1:0] a, input logic we,
                      input logic [DW-1:0] d, input logic lk);
    int n;
    issue(m, a, we, d, lk);
    wait_ready(m, n);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_master(input int m);
    int gap;
    logic [AW-1:0] a;
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        m_valid[m] = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      a = AW'(8 + 4 * m + $urandom_range(0, 3));
      xfer(m, a, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    m_valid[m] = 1'b0;
    m_lock[m]  = 1'b0;
  endtask

  initial begin
    int n;
    int to_k;
    int rd_k;
    int to_cnt;
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    slv_clr = 1'b1;
    m_valid = '0;
    m_addr  = '0;
    m_we    = '0;
    m_wdata = '0;
    m_lock  = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_we", 32'(s_we), 32'(0));
    check("rst_ready", 32'(m_ready), 32'(0));
    check("rst_lock_to", 32'(lock_to), 32'(0));
    check("rst_s_addr", 32'(s_addr), 32'(0));
    check("rst_s_wdata", 32'(s_wdata), 32'(0));
    check("rst_rdata", 32'(m0_rdata), 32'(0));
    @(posedge clk);
    #1;
    slv_clr = 1'b0;
    rst_n   = 1'b1;

    // Write with cycle-exact latency
    issue(0, 4'd0, 1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    check("wr_idle_no_we", 32'(s_we), 32'(0));
    @(negedge clk);
    check("wr_we_c1", 32'(s_we), 32'(1));
    check("wr_data_c1", 32'(s_wdata), 32'(8'hA5));
    check("wr_addr_c1", 32'(s_addr), 32'(0));
    check("wr_ready_early", 32'(m_ready[0]), 32'(0));
    @(negedge clk);
    check("wr_ready_c2", 32'(m_ready[0]), 32'(1));
    check("wr_we_off_c2", 32'(s_we), 32'(0));
    @(posedge clk);
    #1 m_valid[0] = 1'b0;
    check("gpio_pin_a5", 32'(slv_mem[0]), 32'(8'hA5));

    // Read back by the other master
    issue(1, 4'd0, 1'b0, 8'h00, 1'b0);
    wait_ready(1, n);
    check("rd_latency", 32'(n), 32'(3));
    check("rd_m0_quiet", 32'(m_ready[0]), 32'(0));
    @(posedge clk);
    #1 m_valid[1] = 1'b0;

    // Contention from reset: strict alternation, 3 cycles apart
    apply_reset();
    log_m.delete();
    log_c.delete();
    fork
      begin
        xfer(0, 4'd1, 1'b0, 8'h00, 1'b0);
        xfer(0, 4'd2, 1'b0, 8'h00, 1'b0);
        m_valid[0] = 1'b0;
      end
      begin
        xfer(1, 4'd3, 1'b0, 8'h00, 1'b0);
        xfer(1, 4'd4, 1'b0, 8'h00, 1'b0);
        m_valid[1] = 1'b0;
      end
    join
    check("cont_count", 32'(log_m.size()), 32'(4));
    for (int i = 0; i < 4 && i < log_m.size(); i++) begin
      check($sformatf("cont_order_%0d", i), 32'(log_m[i]), 32'(i % 2));
      if (i > 0) check($sformatf("cont_gap_%0d", i), 32'(log_c[i] - log_c[i-1]), 32'(3));
    end

    // Locked read-modify-write keeps m1 out until the write completes
    log_m.delete();
    log_c.delete();
    fork
      begin
        xfer(0, 4'd1, 1'b0, 8'h00, 1'b1);
        xfer(0, 4'd1, 1'b1, 8'h0F, 1'b0);
        m_valid[0] = 1'b0;
        m_lock[0]  = 1'b0;
      end
      begin
        xfer(1, 4'd2, 1'b0, 8'h00, 1'b0);
        m_valid[1] = 1'b0;
      end
    join
    check("rmw_count", 32'(log_m.size()), 32'(3));
    for (int i = 0; i < 3 && i < log_m.size(); i++)
      check($sformatf("rmw_order_%0d", i), 32'(log_m[i]), 32'((i == 2) ? 1 : 0));
    check("rmw_pin", 32'(slv_mem[1]), 32'(8'h0F));

    // Lock timeout: held lock with no traffic is revoked after LT idle cycles
    xfer(0, 4'd3, 1'b0, 8'h00, 1'b1);
    m_valid[0] = 1'b0;
    issue(1, 4'd4, 1'b0, 8'h00, 1'b0);
    to_k = 0;
    rd_k = 0;
    to_cnt = 0;
    for (int k = 1; k <= 30 && rd_k == 0; k++) begin
      @(negedge clk);
      if (lock_to) begin
        to_cnt++;
        if (to_k == 0) to_k = k;
      end
      if (m_ready[1]) rd_k = k;
    end
    check("timeout_cycle", 32'(to_k), 32'(LT + 1));
    check("timeout_width", 32'(to_cnt), 32'(1));
    check("timeout_m1_ready", 32'(rd_k), 32'(LT + 3));
    @(posedge clk);
    #1;
    m_valid[1] = 1'b0;
    m_lock[0]  = 1'b0;

    // Reset during a write's ACCESS cycle
    m_valid[0] = 1'b1;
    m_addr[0]  = 4'd5;
    m_we[0]    = 1'b1;
    m_wdata[0] = 8'h3C;
    m_lock[0]  = 1'b0;
    @(posedge clk);
    #1 check("mid_we_before", 32'(s_we), 32'(1));
    #1 rst_n = 1'b0;
    #1 check("mid_we_dropped", 32'(s_we), 32'(0));
    m_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_no_ready", 32'(m_ready), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_no_write", 32'(slv_mem[5]), 32'(ref_mem[5]));
    log_m.delete();
    log_c.delete();
    fork
      begin
        xfer(1, 4'd6, 1'b0, 8'h00, 1'b0);
        m_valid[1] = 1'b0;
      end
      begin
        xfer(0, 4'd7, 1'b0, 8'h00, 1'b0);
        m_valid[0] = 1'b0;
      end
    join
    check("post_rst_first", 32'((log_m.size() > 0) ? log_m[0] : -1), 32'(0));

    // Randomized traffic on disjoint address ranges
    fork
      rand_master(0);
      rand_master(1);
    join
    repeat (4) @(posedge clk);
    for (int a = 8; a < 16; a++)
      check($sformatf("final_mem_%0d", a), 32'(slv_mem[a]), 32'(ref_mem[a]));
    check("drain_q0", 32'(exp_q0.size()), 32'(0));
    check("drain_q1", 32'(exp_q1.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
